// File: rtl/spi_shift_engine.sv
// spi_shift_engine
//   SPI-style transmit serializer driving the SSD1306 serial pins from the
//   display command sequencer. Provides a programmable SCLK divider, SCLK idle
//   polarity, selectable bit order, chip select, a per-word D/C line and
//   gap-free back-to-back words. An optional receive path is enabled by
//   defining SPI_SHIFT_RX_EN.
//
// Parameters
//   WIDTH      bits per word (>=2)
//   CLK_DIV    clk_in cycles per SCLK half-period (>=1)
//   CPOL       SCLK idle level (0 or 1)
//   MSB_FIRST  1: data_in[WIDTH-1] goes out first, 0: data_in[0] first
//
// Ports
//   clk_in        system clock
//   reset_in      asynchronous active-high reset
//   start_in      word request, taken when start_in & ready_out
//   data_in       word to transmit, sampled on accept
//   dc_in         D/C level for the word, sampled on accept
//   ready_out     engine can accept a word this cycle
//   busy_out      high from the cycle after accept until back in IDLE
//   clk_out       SCLK
//   serial_out    MOSI
//   cs_n_out      chip select, active low
//   dc_out        D/C for the word in flight
//   serial_in     MISO (only used when SPI_SHIFT_RX_EN is defined)
//   data_out      last received word (0 when the receive path is absent)
//   rx_valid_out  one-cycle pulse when data_out updates
module spi_shift_engine #(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 2,
    parameter int CPOL      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dc_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic             clk_out,
    output logic             serial_out,
    output logic             cs_n_out,
    output logic             dc_out,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             rx_valid_out
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic IDLE_CLK = (CPOL != 0);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_HOLD} state_t;

    // Bit currently at the "wire" end of a word in the chosen order.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    // Move the next bit to the wire end of the word.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               ser_q, ser_d;
    logic               cs_n_q, cs_n_d;
    logic               sclk_q, sclk_d;
    logic               dc_q, dc_d;

    logic word_end;
    logic accept;

    // Final clk_in cycle of the last bit's HIGH phase: the only mid-transfer
    // point where a following word can be chained without a gap.
    assign word_end = (state_q == S_HIGH) && (div_q == DIV_LAST) && (bit_q == BIT_LAST);
    assign accept   = start_in && ((state_q == S_IDLE) || word_end);

    assign ready_out  = !reset_in && ((state_q == S_IDLE) || word_end);
    assign busy_out   = (state_q != S_IDLE);
    assign clk_out    = sclk_q;
    assign serial_out = ser_q;
    assign cs_n_out   = cs_n_q;
    assign dc_out     = dc_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ser_d   = ser_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        dc_d    = dc_q;

        case (state_q)
            S_IDLE: ;
            S_LOW: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = S_HIGH;
                    sclk_d  = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_HIGH: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q != BIT_LAST) begin
                        // MOSI only changes on entry to LOW, keeping it
                        // stable across the SCLK rising edge.
                        state_d = S_LOW;
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = advance(shift_q);
                        ser_d   = first_bit(advance(shift_q));
                        sclk_d  = 1'b0;
                    end else begin
                        state_d = S_HOLD;
                        sclk_d  = IDLE_CLK;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = S_IDLE;
                    cs_n_d  = 1'b1;
                    ser_d   = 1'b0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new word (from IDLE or chained at word end) overrides the above.
        if (accept) begin
            state_d = S_LOW;
            div_d   = '0;
            bit_d   = '0;
            shift_d = data_in;
            ser_d   = first_bit(data_in);
            cs_n_d  = 1'b0;
            sclk_d  = 1'b0;
            dc_d    = dc_in;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ser_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= IDLE_CLK;
            dc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ser_q   <= ser_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            dc_q    <= dc_d;
        end
    end

`ifdef SPI_SHIFT_RX_EN
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;

    always_comb begin
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        // Sample on the clk_in edge that raises SCLK; assemble in wire order
        // so the finished word matches the transmit bit order.
        if ((state_q == S_LOW) && (div_q == DIV_LAST)) begin
            rx_shift_d = (MSB_FIRST != 0) ? {rx_shift_q[WIDTH-2:0], serial_in}
                                          : {serial_in, rx_shift_q[WIDTH-1:1]};
        end
        // The last sample was taken at the end of the last LOW phase, so the
        // shift register already holds the complete word here.
        if (word_end) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign data_out     = rx_data_q;
    assign rx_valid_out = rx_valid_q;
`else
    logic unused_serial_in;
    assign unused_serial_in = serial_in;
    assign data_out         = '0;
    assign rx_valid_out     = 1'b0;
`endif

endmodule
